// File: rtl/neuron_serializer_pkg.sv
// Shared constants, state encoding and select helper for the neuron serializer.
//   DATA_W   : width of one neuron word
//   N_WORDS  : words per frame
//   SEL_W    : width of word index / word-mux select
//   LAST_IDX : index of the final word of a frame
package neuron_serializer_pkg;

  localparam int DATA_W   = 16;
  localparam int N_WORDS  = 16;
  localparam int SEL_W    = 5;
  localparam int LAST_IDX = N_WORDS - 1;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAST_IDX);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // The word mux has a 5-bit select but only 16 inputs; the top select bit
  // is forced low so out-of-range selects can never be generated.
  function automatic logic [SEL_W-1:0] word_sel(input logic [3:0] idx4);
    return {1'b0, idx4};
  endfunction

endpackage

// File: rtl/neuron_serializer_if.sv
// Frame-in / word-out stream bundle for the neuron serializer.
//   in_valid/in_ready/in_data : one 16 x 16-bit frame per handshake
//   out_valid/out_ready       : one word per accepted beat
//   out_data/out_index        : current word and its position in the frame
//   out_last                  : current word is the last of the frame
//   frame_done                : one-cycle pulse after the last beat is taken
// Modport master is the environment (producer + consumer); slave is the block.
interface neuron_serializer_if
  import neuron_serializer_pkg::*;
();

  logic                      in_valid;
  logic                      in_ready;
  logic [N_WORDS*DATA_W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          out_index;
  logic                      out_last;
  logic                      frame_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, frame_done
  );

endinterface

// File: rtl/neuron_serializer_mux_16_1.sv
// 16:1 word multiplexer with a 5-bit select.
//   din  : 16 words
//   sel  : word select; values 16..31 produce zero
//   dout : selected word
module mux_16_1
  import neuron_serializer_pkg::*;
(
  input  logic [DATA_W-1:0] din [N_WORDS],
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] dout
);

  // Select one word; the unused upper half of the select space reads as zero.
  always_comb begin
    dout = {DATA_W{1'b0}};
    if (sel[SEL_W-1] == 1'b0) begin
      dout = din[sel[3:0]];
    end else begin
      dout = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/neuron_serializer.sv
// Parallel-to-serial stage between a 16-neuron layer and the next layer's MAC.
// Captures a whole frame in one handshake, then replays it one word per
// accepted beat through the 16:1 word mux.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears bank and control state)
//   clear : synchronous abort of the current frame, bank retained
//   bus   : frame-in / word-out stream (slave side)
module neuron_serializer
  import neuron_serializer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  neuron_serializer_if.slave  bus
);

  state_t            state_r;
  logic [SEL_W-1:0]  idx_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              frame_done_r;
  logic [DATA_W-1:0] bank_r [N_WORDS];

  logic              capture_s;
  logic              accept_s;
  logic              at_last_s;
  logic [SEL_W-1:0]  sel_s;
  logic [DATA_W-1:0] mux_out_s;

  // clear wins over both capture and beat acceptance.
  assign capture_s = (state_r == ST_IDLE) & bus.in_valid & in_ready_r & ~clear;
  assign accept_s  = (state_r == ST_STREAM) & out_valid_r & bus.out_ready & ~clear;
  assign at_last_s = (idx_r == LAST_SEL);
  assign sel_s     = word_sel(idx_r[3:0]);

  // Frame bank: loaded only on an accepted frame, kept across clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WORDS; i++) begin
        bank_r[i] <= {DATA_W{1'b0}};
      end
    end else if (capture_s) begin
      for (int i = 0; i < N_WORDS; i++) begin
        bank_r[i] <= bus.in_data[i*DATA_W +: DATA_W];
      end
    end else begin
      bank_r <= bank_r;
    end
  end

  // Control FSM with word index and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= {SEL_W{1'b0}};
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (clear) begin
        state_r     <= ST_IDLE;
        idx_r       <= {SEL_W{1'b0}};
        out_valid_r <= 1'b0;
        in_ready_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (capture_s) begin
              state_r     <= ST_STREAM;
              idx_r       <= {SEL_W{1'b0}};
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              // First cycle after reset release lands here and raises ready.
              in_ready_r  <= 1'b1;
            end
          end
          ST_STREAM: begin
            if (accept_s) begin
              if (at_last_s) begin
                state_r      <= ST_IDLE;
                idx_r        <= {SEL_W{1'b0}};
                out_valid_r  <= 1'b0;
                in_ready_r   <= 1'b1;
                frame_done_r <= 1'b1;
              end else begin
                idx_r        <= idx_r + SEL_W'(1'b1);
              end
            end else begin
              idx_r <= idx_r;
            end
          end
          default: begin
            state_r     <= ST_IDLE;
            idx_r       <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  mux_16_1 u_mux (
    .din  (bank_r),
    .sel  (sel_s),
    .dout (mux_out_s)
  );

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_data   = mux_out_s;
  assign bus.out_index  = idx_r;
  assign bus.out_last   = out_valid_r & at_last_s;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_neuron_serializer.sv
// Self-checking bench for neuron_serializer: directed scenarios plus a random
// run, all checked every cycle against a queue-based stream model.
module tb_neuron_serializer;
  import neuron_serializer_pkg::*;

  localparam int FW = N_WORDS * DATA_W;

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  neuron_serializer_if bus ();

  neuron_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int      n_checks  = 0;
  int      n_errors  = 0;
  int      cyc       = 0;
  int      last_done = -1;
  beat_t   exp_q[$];
  bit      m_started = 1'b0;
  bit      m_done    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input logic [DATA_W-1:0] base);
    logic [FW-1:0] f;
    for (int i = 0; i < N_WORDS; i++) f[i*DATA_W +: DATA_W] = base + DATA_W'(i);
    return f;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  // Stream model: an accepted frame becomes 16 pending beats; each accepted
  // beat removes the head; clear discards everything pending.
  task automatic model_edge();
    bit    rdy_pre;
    beat_t b;
    rdy_pre = (exp_q.size() == 0) && m_started;
    m_done  = 1'b0;
    if (clear) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (bus.in_valid && rdy_pre) begin
        for (int i = 0; i < N_WORDS; i++) begin
          b.idx  = i;
          b.data = bus.in_data[i*DATA_W +: DATA_W];
          exp_q.push_back(b);
        end
      end
    end else if (bus.out_ready) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) m_done = 1'b1;
    end
    m_started = 1'b1;
  endtask

  task automatic compare_all();
    check_eq("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check_eq("in_ready", 32'(bus.in_ready), 32'((exp_q.size() == 0) && m_started));
    check_eq("frame_done", 32'(bus.frame_done), 32'(m_done));
    if (exp_q.size() != 0) begin
      check_eq("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
      check_eq("out_index", 32'(bus.out_index), 32'(exp_q[0].idx));
      check_eq("out_last", 32'(bus.out_last), 32'(exp_q[0].idx == LAST_IDX));
    end else begin
      check_eq("idle_index", 32'(bus.out_index), 32'd0);
      check_eq("idle_last", 32'(bus.out_last), 32'd0);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check at the next falling edge.
  task automatic step(input bit iv, input logic [FW-1:0] id, input bit ordy, input bit clr);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    clear         = clr;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_started = 1'b0;
    m_done    = 1'b0;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_index", 32'(bus.out_index), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    clear         = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit iv, input logic [FW-1:0] id);
    int n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      step(iv, id, 1'b1, 1'b0);
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [FW-1:0] f;
    int            hold;
    int            n;
    bit            ordy;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);

    // 1: reset values, then ready one cycle after release
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 2: counting frame, consumer always ready
    step(1'b1, mk_frame(16'h0001), 1'b1, 1'b0);
    check_eq("f2_first", 32'(bus.out_data), 32'h0001);
    drain(1'b0, '0);
    check_eq("f2_done", 32'(bus.frame_done), 32'd1);

    // 1 (cont.): reset in the middle of a frame drops it
    step(1'b1, mk_frame(16'h0100), 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);

    // 3: back-pressure for three cycles while word 5 is presented
    step(1'b1, mk_frame(16'h0001), 1'b1, 1'b0);
    hold = 0;
    n    = 0;
    while (exp_q.size() != 0 && n < 64) begin
      ordy = 1'b1;
      if (exp_q[0].idx == 5 && hold < 3) begin
        ordy = 1'b0;
        hold++;
      end
      step(1'b0, '0, ordy, 1'b0);
      if (!ordy) begin
        check_eq("bp_data", 32'(bus.out_data), 32'h0006);
        check_eq("bp_index", 32'(bus.out_index), 32'd5);
      end
      n++;
    end
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

    // 4: in_valid held with other data while streaming is ignored
    step(1'b1, mk_frame(16'h1230), 1'b1, 1'b0);
    drain(1'b1, mk_frame(16'h5500));

    // 5: clear at index 9, then a fresh frame starts from index 0
    step(1'b1, mk_frame(16'h3000), 1'b1, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && exp_q[0].idx != 9 && n < 32) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check_eq("clr_at9", 32'(bus.out_index), 32'd9);
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("clr_valid", 32'(bus.out_valid), 32'd0);
    check_eq("clr_ready", 32'(bus.in_ready), 32'd1);
    check_eq("clr_no_done", 32'(bus.frame_done), 32'd0);
    step(1'b1, mk_frame(16'hA000), 1'b1, 1'b0);
    check_eq("clr_new_idx", 32'(bus.out_index), 32'd0);
    check_eq("clr_new_data", 32'(bus.out_data), 32'hA000);
    drain(1'b0, '0);

    // 6: back-to-back frames with in_valid always high, word 0 = 0x8000
    last_done = -1;
    for (int k = 0; k < 3 * 17 + 4; k++) begin
      f = rand_frame();
      f[DATA_W-1:0] = 16'h8000;
      step(1'b1, f, 1'b1, 1'b0);
      if (exp_q.size() == N_WORDS) check_eq("b2b_8000", 32'(bus.out_data), 32'h8000);
      if (bus.frame_done) begin
        if (last_done >= 0) check_eq("b2b_period", 32'(cyc - last_done), 32'd17);
        last_done = cyc;
      end
    end
    drain(1'b0, '0);

    // Random traffic with occasional clear and one asynchronous reset
    for (int k = 0; k < 800; k++) begin
      if (k == 400) begin
        do_reset();
      end
      step(1'($urandom_range(0, 1)), rand_frame(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end
    drain(1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
